// File: rtl/mac_dot_sequencer.sv
// mac_dot_sequencer: streams B/C pairs into an external FP32 A+B*C unit, feeding
// the accumulator back as A, and returns the final dot product over valid/ready.
module mac_dot_sequencer #(
  parameter int PARM_XLEN    = 32,
  parameter int PARM_LEN_W   = 8,
  parameter int PARM_MAC_LAT = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [PARM_LEN_W-1:0] len_i,
  input  logic [PARM_XLEN-1:0]  init_i,
  input  logic                  elem_valid_i,
  output logic                  elem_ready_o,
  input  logic [PARM_XLEN-1:0]  elem_b_i,
  input  logic [PARM_XLEN-1:0]  elem_c_i,
  output logic [PARM_XLEN-1:0]  mac_a_o,
  output logic [PARM_XLEN-1:0]  mac_b_o,
  output logic [PARM_XLEN-1:0]  mac_c_o,
  input  logic [PARM_XLEN-1:0]  mac_result_i,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [PARM_XLEN-1:0]  res_data_o,
  output logic                  busy_o
);
  localparam int WW = PARM_MAC_LAT > 1 ? $clog2(PARM_MAC_LAT) : 1;
  typedef enum logic [1:0] {IDLE, ACC, WAIT, DONE} state_e;
  state_e                state_q;
  logic [PARM_XLEN-1:0]  acc_q, b_q, c_q;
  logic [PARM_LEN_W-1:0] cnt_q, len_q;
  logic [WW-1:0]         wait_q;
  logic [PARM_LEN_W:0]   cnt_d;
  // one extra bit so a full-range length never wraps the terminal compare
  assign cnt_d        = {1'b0, cnt_q} + {{PARM_LEN_W{1'b0}}, 1'b1};
  assign elem_ready_o = state_q == ACC;
  assign res_valid_o  = state_q == DONE;
  assign busy_o       = state_q != IDLE;
  assign mac_a_o      = acc_q;
  assign res_data_o   = acc_q;
  assign mac_b_o      = b_q;
  assign mac_c_o      = c_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      acc_q   <= '0;
      b_q     <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      wait_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          acc_q   <= init_i;
          len_q   <= len_i;
          cnt_q   <= '0;
          state_q <= len_i == '0 ? DONE : ACC;
        end
        ACC: if (elem_valid_i) begin
          b_q     <= elem_b_i;
          c_q     <= elem_c_i;
          wait_q  <= WW'(PARM_MAC_LAT - 1);
          state_q <= WAIT;
        end
        WAIT: if (wait_q != '0) wait_q <= wait_q - WW'(1);
        else begin
          acc_q   <= mac_result_i;
          cnt_q   <= cnt_d[PARM_LEN_W-1:0];
          state_q <= cnt_d == {1'b0, len_q} ? DONE : ACC;
        end
        DONE: if (res_ready_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mac_dot_sequencer.sv
// tb_mac_dot_sequencer: directed bench; u1 uses LAT=1/LEN_W=8, u3 uses LAT=3/LEN_W=4.
// Both share stimulus; s selects which instance the running test observes.
module tb_mac_dot_sequencer;
  logic        clk = 0, rst = 0, start = 0, valid = 0, res_ready = 0;
  logic [7:0]  len = 0;
  logic [31:0] init = 0, eb = 0, ec = 0;
  logic        rdy1, rv1, busy1, rdy3, rv3, busy3;
  logic [31:0] a1, b1, c1, r1, d1, a3, b3, c3, r3, d3;
  bit          s = 0;
  int          errs = 0, checks = 0, cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic int fp2i(logic [31:0] x);
    int e = int'(x[30:23]) - 127;
    if (x == 0 || e < 0 || e > 23) return 0;
    return int'({8'b0, 1'b1, x[22:0]} >> (23 - e));
  endfunction
  function automatic logic [31:0] i2fp(int v);
    int p = 0;
    logic [31:0] m;
    if (v <= 0) return 0;
    for (int i = 0; i < 31; i++) if ((v >> i) != 0) p = i;
    if (p > 23) return 0;
    m = 32'(v) << (23 - p);
    return {1'b0, 8'(127 + p), m[22:0]};
  endfunction
  function automatic logic [31:0] fmac(logic [31:0] a, logic [31:0] b, logic [31:0] c);
    return i2fp(fp2i(a) + fp2i(b) * fp2i(c));
  endfunction
  assign r1 = fmac(a1, b1, c1);
  assign r3 = fmac(a3, b3, c3);
  mac_dot_sequencer #(.PARM_XLEN(32), .PARM_LEN_W(8), .PARM_MAC_LAT(1)) u1 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .len_i(len), .init_i(init),
    .elem_valid_i(valid), .elem_ready_o(rdy1), .elem_b_i(eb), .elem_c_i(ec),
    .mac_a_o(a1), .mac_b_o(b1), .mac_c_o(c1), .mac_result_i(r1),
    .res_valid_o(rv1), .res_ready_i(res_ready), .res_data_o(d1), .busy_o(busy1));
  mac_dot_sequencer #(.PARM_XLEN(32), .PARM_LEN_W(4), .PARM_MAC_LAT(3)) u3 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .len_i(len[3:0]), .init_i(init),
    .elem_valid_i(valid), .elem_ready_o(rdy3), .elem_b_i(eb), .elem_c_i(ec),
    .mac_a_o(a3), .mac_b_o(b3), .mac_c_o(c3), .mac_result_i(r3),
    .res_valid_o(rv3), .res_ready_i(res_ready), .res_data_o(d3), .busy_o(busy3));
  logic        rdy, rv, busy;
  logic [31:0] ma, mb, mc, rd;
  assign rdy  = s ? rdy3 : rdy1;
  assign rv   = s ? rv3 : rv1;
  assign busy = s ? busy3 : busy1;
  assign ma   = s ? a3 : a1;
  assign mb   = s ? b3 : b1;
  assign mc   = s ? c3 : c1;
  assign rd   = s ? d3 : d1;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst = 1;
    tick();
    rst = 0;
    tick();
  endtask
  task automatic go(input logic [7:0] l, input logic [31:0] i);
    start = 1; len = l; init = i;
    tick();
    start = 0;
  endtask
  task automatic send(input logic [31:0] b, input logic [31:0] c);
    bit ok = 0;
    valid = 1; eb = b; ec = c;
    for (int i = 0; i < 50 && !ok; i++) begin
      ok = rdy;
      tick();
    end
    valid = 0;
    checks++;
    if (!ok) begin errs++; $display("FAIL send_timeout: no handshake within 50 cycles"); end
  endtask
  task automatic test_reset;
    s = 0;
    rst = 1;
    #1;
    checks++;
    if ({rdy1, rv1, busy1, rdy3, rv3, busy3} !== 6'b0) begin errs++; $display("FAIL reset_flags: got %b want 000000", {rdy1, rv1, busy1, rdy3, rv3, busy3}); end
    checks++;
    if ({a1, b1, c1, d1} !== 128'b0) begin errs++; $display("FAIL reset_data: got %h want 0", {a1, b1, c1, d1}); end
    tick();
    rst = 0;
    tick();
  endtask
  task automatic test_basic;
    s = 0;
    do_reset();
    go(8'd2, 32'h0);
    checks++;
    if (busy !== 1 || rdy !== 1) begin errs++; $display("FAIL basic_acc: busy=%b rdy=%b want 1 1", busy, rdy); end
    send(32'h3F800000, 32'h40400000);
    checks++;
    if (rdy !== 0 || mb !== 32'h3F800000 || mc !== 32'h40400000) begin errs++; $display("FAIL basic_wait: rdy=%b b=%h c=%h want 0 3f800000 40400000", rdy, mb, mc); end
    send(32'h40000000, 32'h40800000);
    checks++;
    if (rv !== 0) begin errs++; $display("FAIL basic_early_valid: got %b want 0", rv); end
    tick();
    checks++;
    if (rv !== 1 || rd !== 32'h41300000) begin errs++; $display("FAIL basic_result: valid=%b data=%h want 1 41300000", rv, rd); end
    res_ready = 1;
    tick();
    res_ready = 0;
    checks++;
    if (busy !== 0 || rv !== 0) begin errs++; $display("FAIL basic_idle: busy=%b valid=%b want 0 0", busy, rv); end
  endtask
  task automatic test_zero_len;
    s = 0;
    do_reset();
    go(8'd0, 32'h40A00000);
    checks++;
    if (rv !== 1 || rd !== 32'h40A00000 || rdy !== 0) begin errs++; $display("FAIL zero_len: valid=%b data=%h rdy=%b want 1 40a00000 0", rv, rd, rdy); end
    res_ready = 1;
    tick();
    res_ready = 0;
  endtask
  task automatic test_backpressure;
    s = 0;
    do_reset();
    go(8'd2, 32'h0);
    send(32'h3F800000, 32'h40400000);
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rdy !== 1 || rd !== 32'h40400000) begin errs++; $display("FAIL gap_%0d: rdy=%b acc=%h want 1 40400000", i, rdy, rd); end
      tick();
    end
    send(32'h40000000, 32'h40800000);
    tick();
    for (int i = 0; i < 5; i++) begin
      start = i == 2; len = 8'd5; init = 32'h40A00000;
      checks++;
      if (rv !== 1 || busy !== 1 || rd !== 32'h41300000) begin errs++; $display("FAIL hold_%0d: valid=%b busy=%b data=%h want 1 1 41300000", i, rv, busy, rd); end
      tick();
    end
    start = 0;
    res_ready = 1;
    checks++;
    if (busy !== 1) begin errs++; $display("FAIL busy_before_hs: got %b want 1", busy); end
    tick();
    res_ready = 0;
    checks++;
    if (busy !== 0 || rv !== 0 || rd !== 32'h41300000) begin errs++; $display("FAIL after_hs: busy=%b valid=%b data=%h want 0 0 41300000", busy, rv, rd); end
  endtask
  task automatic test_latency;
    int hs[$];
    s = 1;
    do_reset();
    go(8'd3, 32'h3F800000);
    valid = 1; eb = 32'h3F800000; ec = 32'h3F800000;
    for (int i = 0; i < 40 && hs.size() < 3; i++) begin
      if (rdy) hs.push_back(cyc);
      else begin
        checks++;
        if (mb !== 32'h3F800000 || mc !== 32'h3F800000) begin errs++; $display("FAIL wait_stable: b=%h c=%h want 3f800000", mb, mc); end
      end
      tick();
    end
    valid = 0;
    checks++;
    if (hs.size() != 3 || hs[1] - hs[0] != 4 || hs[2] - hs[1] != 4) begin errs++; $display("FAIL lat_spacing: got %0d handshakes, want 3 spaced 4", hs.size()); end
    tick();
    tick();
    checks++;
    if (rv !== 0) begin errs++; $display("FAIL lat_early: valid=%b want 0", rv); end
    tick();
    checks++;
    if (rv !== 1 || rd !== 32'h40800000) begin errs++; $display("FAIL lat_result: valid=%b data=%h want 1 40800000", rv, rd); end
    res_ready = 1;
    tick();
    res_ready = 0;
  endtask
  task automatic test_reset_mid;
    s = 0;
    do_reset();
    go(8'd4, 32'h0);
    send(32'h3F800000, 32'h40400000);
    tick();
    rst = 1;
    #1;
    checks++;
    if ({rdy, rv, busy} !== 3'b0 || {ma, mb, mc, rd} !== 128'b0) begin errs++; $display("FAIL mid_reset: flags=%b a=%h b=%h want 0", {rdy, rv, busy}, ma, mb); end
    tick();
    rst = 0;
    tick();
    go(8'd1, 32'h0);
    send(32'h3F800000, 32'h40000000);
    tick();
    checks++;
    if (rv !== 1 || rd !== 32'h40000000) begin errs++; $display("FAIL post_reset_run: valid=%b data=%h want 1 40000000", rv, rd); end
    res_ready = 1;
    tick();
    res_ready = 0;
  endtask
  task automatic test_max_len;
    int n = 0;
    s = 1;
    do_reset();
    go(8'd15, 32'h0);
    valid = 1; eb = 32'h3F800000; ec = 32'h3F800000;
    for (int i = 0; i < 200 && !rv; i++) begin
      if (rdy) n++;
      tick();
    end
    valid = 0;
    checks++;
    if (n != 15) begin errs++; $display("FAIL max_len_count: got %0d want 15", n); end
    checks++;
    if (rv !== 1 || rd !== 32'h41700000) begin errs++; $display("FAIL max_len_result: valid=%b data=%h want 1 41700000", rv, rd); end
    res_ready = 1;
    tick();
    res_ready = 0;
  endtask
  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_backpressure();
    test_latency();
    test_reset_mid();
    test_max_len();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
